// File: rtl/tx_link_ctrl.sv
// Purpose : transmitter-side link sequencer (elec idle -> comma training -> data with SKP insertion).
// Latency : IDLE->TRAIN takes 1 cycle; data words appear at the slot boundary that follows their txReady cycle.
// Backpres: txReady is a one-cycle offer per data slot; if txValid is low then, a COMMA fill word goes out instead.
//
// Ports   : clk/rst/enb       - clock, sync active-high reset, clock enable (rst wins over enb)
//           start, cfgS       - link up/down request level, lane width config (sampled only in IDLE)
//           txValid/txData    - upstream word handshake, txReady pulse marks the accepting cycle
//           dataS, K, TxElecIdle, dataIn/dataIn16/dataIn32 - registered transmitter controls
//           linkUp            - high while in DATA
//           wordCount/skpCount- statistics, built only when TX_STATS_EN is defined (else tied to 0)
module tx_link_ctrl #(
    parameter int         TRAIN_WORDS  = 16,
    parameter int         SKP_INTERVAL = 32,
    parameter logic [7:0] COMMA        = 8'hBC,
    parameter logic [7:0] SKP          = 8'h1C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enb,
    input  logic        start,
    input  logic [1:0]  cfgS,
    input  logic        txValid,
    input  logic [31:0] txData,
    output logic        txReady,
    output logic [1:0]  dataS,
    output logic        K,
    output logic        TxElecIdle,
    output logic [7:0]  dataIn,
    output logic [15:0] dataIn16,
    output logic [31:0] dataIn32,
    output logic        linkUp,
    output logic [15:0] wordCount,
    output logic [15:0] skpCount
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TRAIN = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;

    logic [1:0]  state;
    logic [5:0]  slotCnt;
    logic [7:0]  trainCnt;
    logic [7:0]  posCnt;
    logic [31:0] word;

    logic [5:0]  slotLast;
    logic        atBoundary;
    logic        preBoundary;
    logic        trainDone;
    logic [7:0]  posNext;
    logic        skpNext;
    logic        loadSkp;
    logic        loadData;
    logic [31:0] slotWord;

    // Same symbol on every active lane, zero above the configured width.
    function automatic logic [31:0] symWord(input logic [7:0] sym, input logic [1:0] sel);
        case (sel)
            2'b00:   return {24'd0, sym};
            2'b01:   return {16'd0, sym, sym};
            default: return {sym, sym, sym, sym};
        endcase
    endfunction

    function automatic logic [31:0] maskWord(input logic [31:0] w, input logic [1:0] sel);
        case (sel)
            2'b00:   return {24'd0, w[7:0]};
            2'b01:   return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // Slot is 10 bit-clocks per byte lane in use.
    always_comb begin
        case (dataS)
            2'b00:   slotLast = 6'd9;
            2'b01:   slotLast = 6'd19;
            default: slotLast = 6'd39;
        endcase
    end

    assign atBoundary  = (slotCnt == slotLast);
    assign preBoundary = (slotCnt == slotLast - 6'd1);
    assign trainDone   = (trainCnt == 8'(TRAIN_WORDS - 1));
    // posCnt names the slot currently on the wire; posNext is the slot about to be loaded.
    // Entering DATA always loads position 0, which can never be the SKP slot.
    assign posNext     = (posCnt == 8'(SKP_INTERVAL - 1)) ? 8'd0 : posCnt + 8'd1;
    assign skpNext     = (state == DATA) && (posNext == 8'(SKP_INTERVAL - 1));
    assign loadSkp     = skpNext;
    assign loadData    = !loadSkp && txReady && txValid;
    assign slotWord    = loadSkp  ? symWord(SKP, dataS) :
                         loadData ? maskWord(txData, dataS) :
                                    symWord(COMMA, dataS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            slotCnt    <= 6'd0;
            trainCnt   <= 8'd0;
            posCnt     <= 8'd0;
            word       <= 32'd0;
            dataS      <= 2'b00;
            K          <= 1'b0;
            TxElecIdle <= 1'b1;
            txReady    <= 1'b0;
            linkUp     <= 1'b0;
        end else if (enb) begin
            txReady <= 1'b0;
            case (state)
                IDLE: begin
                    dataS      <= cfgS;
                    slotCnt    <= 6'd0;
                    linkUp     <= 1'b0;
                    if (start) begin
                        // dataS updates on this same edge, so size the first comma from cfgS.
                        state      <= TRAIN;
                        trainCnt   <= 8'd0;
                        TxElecIdle <= 1'b0;
                        K          <= 1'b1;
                        word       <= symWord(COMMA, cfgS);
                    end else begin
                        TxElecIdle <= 1'b1;
                        K          <= 1'b0;
                        word       <= 32'd0;
                    end
                end
                TRAIN, DATA: begin
                    if (atBoundary) begin
                        slotCnt <= 6'd0;
                        if (!start) begin
                            // Link drop takes priority over any SKP or data load.
                            state      <= IDLE;
                            TxElecIdle <= 1'b1;
                            K          <= 1'b0;
                            word       <= 32'd0;
                            linkUp     <= 1'b0;
                        end else if (state == DATA || trainDone) begin
                            state  <= DATA;
                            linkUp <= 1'b1;
                            posCnt <= (state == DATA) ? posNext : 8'd0;
                            word   <= slotWord;
                            K      <= !loadData;
                        end else begin
                            trainCnt <= trainCnt + 8'd1;
                        end
                    end else begin
                        slotCnt <= slotCnt + 6'd1;
                        // Offer the upcoming slot one cycle before it is loaded.
                        if (preBoundary && start && ((state == DATA && !skpNext) ||
                                                     (state == TRAIN && trainDone)))
                            txReady <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dataIn   = word[7:0];
    assign dataIn16 = word[15:0];
    assign dataIn32 = word;

`ifdef TX_STATS_EN
    logic        loadSlot;
    logic [15:0] wordCnt;
    logic [15:0] skpCnt;

    assign loadSlot = (state != IDLE) && atBoundary && start && (state == DATA || trainDone);

    always_ff @(posedge clk) begin
        if (rst) begin
            wordCnt <= 16'd0;
            skpCnt  <= 16'd0;
        end else if (enb && loadSlot) begin
            if (loadData) wordCnt <= wordCnt + 16'd1;
            if (loadSkp)  skpCnt  <= skpCnt + 16'd1;
        end
    end

    assign wordCount = wordCnt;
    assign skpCount  = skpCnt;
`else
    assign wordCount = 16'd0;
    assign skpCount  = 16'd0;
`endif

endmodule

// File: tb/tb_tx_link_ctrl.sv
// Purpose : directed bench for tx_link_ctrl (TRAIN_WORDS=4, SKP_INTERVAL=4).
// Latency : expected values are hand-derived cycle numbers counted from the start request.
// Backpres: upstream held valid or idle per test; statistics expected as 0 when not built.
module tb_tx_link_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enb;
    logic        start;
    logic [1:0]  cfgS;
    logic        txValid;
    logic [31:0] txData;
    logic        txReady;
    logic [1:0]  dataS;
    logic        K;
    logic        TxElecIdle;
    logic [7:0]  dataIn;
    logic [15:0] dataIn16;
    logic [31:0] dataIn32;
    logic        linkUp;
    logic [15:0] wordCount;
    logic [15:0] skpCount;

    int nTests = 0;
    int nFail  = 0;
    int cyc    = 0;
    int readyPulses = 0;
    int bad;

`ifdef TX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    always #5 clk = ~clk;

    tx_link_ctrl #(
        .TRAIN_WORDS (4),
        .SKP_INTERVAL(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .start     (start),
        .cfgS      (cfgS),
        .txValid   (txValid),
        .txData    (txData),
        .txReady   (txReady),
        .dataS     (dataS),
        .K         (K),
        .TxElecIdle(TxElecIdle),
        .dataIn    (dataIn),
        .dataIn16  (dataIn16),
        .dataIn32  (dataIn32),
        .linkUp    (linkUp),
        .wordCount (wordCount),
        .skpCount  (skpCount)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (txReady) readyPulses++;
    endtask

    task automatic runTo(input int n);
        while (cyc < n) tick();
    endtask

    function automatic logic [31:0] statExp(input int v);
        return STATS ? 32'(v) : 32'd0;
    endfunction

    task automatic chkReset(input string tag);
        chk({tag, "_elecidle"}, 32'(TxElecIdle), 32'd1);
        chk({tag, "_k"},        32'(K),          32'd0);
        chk({tag, "_data32"},   dataIn32,        32'd0);
        chk({tag, "_linkup"},   32'(linkUp),     32'd0);
        chk({tag, "_txready"},  32'(txReady),    32'd0);
        chk({tag, "_datas"},    32'(dataS),      32'd0);
        chk({tag, "_wordcnt"},  32'(wordCount),  32'd0);
        chk({tag, "_skpcnt"},   32'(skpCount),   32'd0);
    endtask

    initial begin
        rst = 1'b1; enb = 1'b1; start = 1'b0; cfgS = 2'b00;
        txValid = 1'b0; txData = 32'd0;

        // 1: reset then a long idle with start low
        tick(); tick();
        chkReset("rst");
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (TxElecIdle !== 1'b1 || K !== 1'b0 || linkUp !== 1'b0 || txReady !== 1'b0) bad++;
        end
        chk("idle_hold", 32'(bad), 32'd0);

        // 2: 8-bit training, four 10-cycle comma slots, data at cycle 41
        cfgS = 2'b00; start = 1'b1; cyc = 0; bad = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (dataIn !== 8'hBC || K !== 1'b1 || TxElecIdle !== 1'b0 || linkUp !== 1'b0) bad++;
        end
        chk("train8_words", 32'(bad), 32'd0);
        chk("train8_ready_last", 32'(txReady), 32'd1);
        tick();
        chk("train8_linkup41", 32'(linkUp), 32'd1);
        chk("train8_fill41", {23'd0, K, dataIn}, {23'd0, 1'b1, 8'hBC});
        rst = 1'b1; start = 1'b0; tick(); rst = 1'b0;

        // 3/4: 32-bit data, continuous valid, SKP every 4th slot
        cfgS = 2'b10; txValid = 1'b1; txData = 32'hDEADBEEF; start = 1'b1; cyc = 0;
        runTo(160);
        chk("d32_ready160", 32'(txReady), 32'd1);
        chk("d32_train_word", dataIn32, 32'hBCBCBCBC);
        runTo(161);
        chk("d32_word161", dataIn32, 32'hDEADBEEF);
        chk("d32_k161", 32'(K), 32'd0);
        chk("d32_linkup161", 32'(linkUp), 32'd1);
        chk("d32_wc161", 32'(wordCount), statExp(1));
        txData = 32'h12345678; readyPulses = 0;
        runTo(201);
        chk("d32_word201", dataIn32, 32'h12345678);
        runTo(280);
        chk("skp_noready280", 32'(txReady), 32'd0);
        runTo(281);
        chk("skp_word281", dataIn32, 32'h1C1C1C1C);
        chk("skp_k281", 32'(K), 32'd1);
        chk("skp_cnt281", 32'(skpCount), statExp(1));
        chk("skp_wc281", 32'(wordCount), statExp(3));
        cfgS = 2'b00;
        runTo(320);
        chk("d32_ready320", 32'(txReady), 32'd1);
        runTo(321);
        chk("d32_word321_k", 32'(K), 32'd0);
        chk("d32_pulses", 32'(readyPulses), 32'd3);
        chk("d32_wc321", 32'(wordCount), statExp(4));

        // 6: cfgS change in DATA ignored; reset mid-word
        runTo(330);
        chk("cfg_ignored", 32'(dataS), 32'd2);
        rst = 1'b1; tick(); rst = 1'b0;
        chkReset("midrst");

        // 5: 16-bit fill words, start dropped mid-slot
        cfgS = 2'b01; txValid = 1'b0; start = 1'b1; cyc = 0;
        runTo(80);
        chk("d16_ready80", 32'(txReady), 32'd1);
        runTo(81);
        chk("d16_fill81", dataIn32, 32'h0000BCBC);
        chk("d16_fillk81", 32'(K), 32'd1);
        chk("d16_linkup81", 32'(linkUp), 32'd1);
        chk("d16_datas", 32'(dataS), 32'd1);
        runTo(105);
        start = 1'b0;
        runTo(120);
        chk("drop_still_up120", {30'd0, linkUp, TxElecIdle}, {30'd0, 1'b1, 1'b0});
        chk("drop_noready120", 32'(txReady), 32'd0);
        runTo(121);
        chk("drop_idle121", {29'd0, TxElecIdle, linkUp, K}, {29'd0, 1'b1, 1'b0, 1'b0});
        chk("drop_bus121", 32'(dataIn16), 32'd0);
        chk("d16_wc", 32'(wordCount), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/tx_link_ctrl.md
Name: tx_link_ctrl

Overview:
- Sequencer in front of the transmitter. It owns the transmitter's control inputs: dataS, K, TxElecIdle and the 8/16/32-bit data buses.
- Walks the link through electrical idle, then a comma training burst, then a data phase with periodic SKP insertion.
- Accepts upstream words through a valid/ready handshake.
- Sits between the packet source and the transmitter, on the transmitter's clock domain.

Parameters:
TRAIN_WORDS, 16, number of all-comma words sent in TRAIN before entering DATA (1..255)
SKP_INTERVAL, 32, data-phase word slots between SKP words (2..255)
COMMA, 8'hBC, K28.5 symbol used for training and fill
SKP, 8'h1C, K28.0 symbol used for the SKP word

Ports:
clk  input  1  transmitter bit clock
rst  input  1  synchronous active-high reset
enb  input  1  clock enable; when low, all state and outputs hold
start  input  1  level; 1 requests the link up, 0 requests the link down
cfgS  input  2  width config: 00=8b, 01=16b, 10/11=32b; sampled only in IDLE
txValid  input  1  upstream word valid
txData  input  32  upstream word; bytes above the configured width are ignored
txReady  output  1  one-cycle pulse when the current slot accepts txData
dataS  output  2  width select to the transmitter (registered copy of cfgS)
K  output  1  1 = control symbols on the data buses
TxElecIdle  output  1  1 = transmitter in electrical idle
dataIn  output  8  byte 0 to the transmitter
dataIn16  output  16  16-bit word to the transmitter
dataIn32  output  32  32-bit word to the transmitter
linkUp  output  1  1 while in DATA
wordCount  output  16  data words accepted (TX_STATS_EN only)
skpCount  output  16  SKP words sent (TX_STATS_EN only)

Behaviour:
- Reset values: state=IDLE, TxElecIdle=1, K=0, data buses=0, dataS=00, txReady=0, linkUp=0, counters=0.
- rst takes priority over enb. rst in any state returns to IDLE on the next edge and aborts the current word.
- All outputs are registered. Every state update is gated by enb.
- Word slot length is L = 10*B cycles, where B = 1, 2 or 4 bytes for the latched dataS.
- A slot counter runs 0..L-1. Data outputs change only when the slot counter wraps, at the "slot boundary".
- Symbol word: every active byte lane carries the same symbol; lanes above B carry 0.
- Data outputs are driven for every B: dataIn is lane 0, dataIn16 is lanes 1:0, dataIn32 is all lanes.

States:
- IDLE
  - TxElecIdle=1, K=0, buses=0.
  - dataS<=cfgS every cycle.
  - start=1 -> TRAIN. The first training word appears on the next cycle, and the slot counter restarts at 0.
- TRAIN
  - TxElecIdle=0, K=1, COMMA word in every slot.
  - After TRAIN_WORDS completed slots -> DATA.
  - start=0 at a slot boundary -> IDLE.
- DATA
  - linkUp=1.
  - A slot-position counter runs 0..SKP_INTERVAL-1. Position SKP_INTERVAL-1 is a SKP slot: SKP word, K=1, txReady not asserted.
  - All other slots: txReady pulses on the cycle before the boundary.
    - If txValid is also 1 on that cycle, txData is loaded at the boundary with K=0.
    - Otherwise a COMMA fill word is loaded with K=1.
  - start=0 is acted on only at a slot boundary. The current word always completes; no txReady is issued for the next slot; the controller goes to IDLE, and TxElecIdle=1 from that boundary.
  - If a SKP slot and a start drop coincide, the drop wins and the SKP is not sent.
- cfgS changes outside IDLE have no effect.
- Counters wrap modulo 2^16.

Optional Feature:
TX_STATS_EN
- Defined:
  - wordCount increments on each accepted txData word.
  - skpCount increments on each SKP word loaded.
  - Both clear on rst only.
- Not defined: wordCount and skpCount are tied to 0 and the counter logic is not built.

Test Plan:
1. rst=1 for 2 cycles, then start=0 for 50 cycles -> TxElecIdle=1, K=0, linkUp=0, txReady=0 throughout.
2. cfgS=00, start=1 with TRAIN_WORDS=4 -> four 10-cycle slots of dataIn=8'hBC, K=1; then linkUp=1 with first data slot at cycle 41.
3. cfgS=10, DATA phase, txValid=1, txData=32'hDEADBEEF -> txReady pulses once per 40 cycles; next slot dataIn32=32'hDEADBEEF, K=0; wordCount=1.
4. DATA with SKP_INTERVAL=4, txValid=1 continuously -> slot 3 carries dataIn32=32'h1C1C1C1C, K=1, no txReady; pattern repeats every 4 slots; skpCount increments.
5. cfgS=01, txValid=0 in DATA -> fill words dataIn16=16'hBCBC, K=1; start dropped mid-slot -> slot completes, then TxElecIdle=1 and linkUp=0.
6. rst asserted mid-word in DATA -> next cycle all outputs at reset values; cfgS change during DATA leaves dataS unchanged.
